tmr_cmp: RTL and testbench
==========================

Name: tmr_cmp

Overview:
- Compare/PWM stage directly downstream of the timer counter in the SimpleRISC SoC.
- Consumes the live 16-bit count (TMR), period (PR) and enable (EN_TMR).
- Produces a PWM waveform, sticky match/overflow flags and a level interrupt.
- Exposes a small memory-mapped register file (CCR, CTRL, STATUS) on the core's peripheral bus; the CCR is double-buffered so duty-cycle updates take effect only at period boundaries.

Parameters:
- W, 16, counter/compare width; must match the counter width.
- ADDR_W, 2, register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- TMR  in  W  live count from the timer counter.
- PR  in  W  period value, also driven to the counter.
- EN_TMR  in  1  counter enable, same signal the counter sees.
- wr_en  in  1  bus write strobe, one cycle per write.
- rd_en  in  1  bus read strobe.
- addr  in  ADDR_W  register select: 0=CCR, 1=CTRL, 2=STATUS, 3=reserved.
- wr_data  in  W  bus write data.
- rd_data  out  W  registered read data.
- pwm_out  out  1  PWM output.
- irq  out  1  level interrupt to the core.

Behaviour:
- Reset (rst_n=0, async): ccr_shadow=0, ccr_active=0, CTRL=0, match_f=0, ovf_f=0, pwm_out=0, irq=0, rd_data=0. Reset asserted mid-period clears everything immediately; there is no pending state.
- CTRL bits:
  - [0] pwm_en
  - [1] ie_match
  - [2] ie_ovf
  - [3] pwm_pol (1 = invert)
  - other bits read 0 and ignore writes.
- Events, evaluated combinationally on the current TMR each cycle:
  - ovf_ev = EN_TMR & (TMR >= PR); the counter wraps to 0 on the next edge.
  - match_ev = EN_TMR & (TMR == ccr_active).
- CCR write (addr 0) loads ccr_shadow only.
- ccr_active <= ccr_shadow on:
  - any cycle with ovf_ev, or
  - any cycle with EN_TMR=0, so a stopped timer takes updates immediately.
- A CCR write in the same cycle as ovf_ev: the new wr_data is written to the shadow; ccr_active loads the old shadow value. The new value becomes active at the following boundary.
- PWM, registered with 1-cycle latency:
  - raw = pwm_en & EN_TMR & (TMR < ccr_active).
  - pwm_out <= raw ^ pwm_pol.
  - Boundaries: ccr_active=0 gives constant inactive; ccr_active>PR gives constant active (100%).
  - With EN_TMR=0 or pwm_en=0, pwm_out = pwm_pol.
- Flags:
  - match_f and ovf_f are sticky; each is set on its event.
  - STATUS write (addr 2) is write-1-to-clear: bit0 match_f, bit1 ovf_f.
  - Set and clear in the same cycle: set wins, flag stays 1.
- irq <= (match_f & ie_match) | (ovf_f & ie_ovf), registered.
  - irq rises 2 cycles after the event edge: flag on cycle+1, irq on cycle+2.
  - irq falls 1 cycle after the flag clears.
- Read: on rd_en, rd_data <= selected register (CCR returns ccr_shadow; STATUS = {…0, ovf_f, match_f}; reserved = 0). rd_data is valid the cycle after rd_en and holds until the next rd_en.
- Arithmetic: all comparisons are unsigned W-bit; no wrap arithmetic inside this block.
- Simultaneous wr_en and rd_en to the same address: read returns the pre-write value.

Decomposition:
- Shared package/header (tmr_defs): register address constants (TMR_CCR=0, TMR_CTRL=1, TMR_STAT=2), CTRL bit indices, STATUS bit indices. The counter and bus decoder include it too.
- One natural sub-module: tmr_regs, holding the register file, W1C logic and read mux. The compare/PWM/event logic stays in tmr_cmp.

Test Plan:
- PR=9, CCR=3, pwm_en=1, EN_TMR=1 -> pwm_out high 3 of every 10 cycles, rising 1 cycle after TMR=0; match_f sets after TMR=3.
- While running with PR=9, CCR=3, write CCR=7 at TMR=5 -> duty stays 3 until the wrap; the next period is high 7 cycles. Write exactly at TMR=9 -> 7 takes effect one period later.
- ie_ovf=1, PR=4 -> ovf_f=1 one cycle after TMR=4 and irq one cycle later. W1C write 0x2 in a non-overflow cycle -> irq drops next cycle. W1C coinciding with TMR=4 -> ovf_f stays 1.
- Boundaries:
  - CCR=0 -> pwm_out constantly 0.
  - CCR=12 with PR=9 -> constantly 1.
  - pwm_pol=1 inverts both.
  - EN_TMR=0 -> pwm_out=pwm_pol and a CCR write reaches ccr_active in 1 cycle.
- Assert rst_n=0 mid-period with flags set and irq=1 -> all outputs 0 immediately, without waiting for a clock edge. Registers read back 0 after release.
- Read CCR/CTRL/STATUS after known writes -> values appear on rd_data exactly 1 cycle after rd_en; reserved address reads 0.

Source files
------------

// File: rtl/tmr_cmp_pkg.sv
// Shared definitions for the timer compare/PWM stage: register map, CTRL and
// STATUS bit positions, and the packed CTRL register layout.
package tmr_cmp_pkg;

  localparam int TMR_CCR  = 0;
  localparam int TMR_CTRL = 1;
  localparam int TMR_STAT = 2;

  localparam int CTRL_PWM_EN   = 0;
  localparam int CTRL_IE_MATCH = 1;
  localparam int CTRL_IE_OVF   = 2;
  localparam int CTRL_PWM_POL  = 3;
  localparam int CTRL_W        = 4;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  typedef struct packed {
    logic pwm_pol;
    logic ie_ovf;
    logic ie_match;
    logic pwm_en;
  } ctrl_t;

endpackage

// File: rtl/tmr_regs.sv
// Bus-visible register file for tmr_cmp: CCR shadow, CTRL, sticky W1C flags
// and the registered read port.
module tmr_regs
  import tmr_cmp_pkg::*;
#(
  parameter int W      = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wr_data,
  input  logic              match_ev,
  input  logic              ovf_ev,
  output logic [W-1:0]      ccr_shadow,
  output ctrl_t             ctrl,
  output logic              match_f,
  output logic              ovf_f,
  output logic [W-1:0]      rd_data
);

  logic         wr_ccr;
  logic         wr_ctrl;
  logic         wr_stat;
  logic         clr_match;
  logic         clr_ovf;
  logic [W-1:0] rd_mux;

  assign wr_ccr    = wr_en && (addr == ADDR_W'(TMR_CCR));
  assign wr_ctrl   = wr_en && (addr == ADDR_W'(TMR_CTRL));
  assign wr_stat   = wr_en && (addr == ADDR_W'(TMR_STAT));
  assign clr_match = wr_stat && wr_data[STAT_MATCH];
  assign clr_ovf   = wr_stat && wr_data[STAT_OVF];

  // NOTE: rd_mux gets a full default before the case so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_W'(TMR_CCR):  rd_mux = ccr_shadow;
      ADDR_W'(TMR_CTRL): rd_mux[CTRL_W-1:0] = ctrl;
      ADDR_W'(TMR_STAT): begin
        rd_mux[STAT_MATCH] = match_f;
        rd_mux[STAT_OVF]   = ovf_f;
      end
      default: rd_mux = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments, so a same-cycle read sees the
  // pre-write register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_shadow <= '0;
      ctrl       <= '0;
      match_f    <= 1'b0;
      ovf_f      <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (wr_ccr)  ccr_shadow <= wr_data;
      if (wr_ctrl) ctrl       <= ctrl_t'(wr_data[CTRL_W-1:0]);
      // A new event outranks a simultaneous write-1-to-clear.
      match_f <= match_ev | (match_f & ~clr_match);
      ovf_f   <= ovf_ev   | (ovf_f   & ~clr_ovf);
      if (rd_en)   rd_data <= rd_mux;
    end
  end

endmodule

// File: rtl/tmr_cmp.sv
// Compare/PWM stage fed by the live timer count: period-boundary CCR reload,
// registered PWM output and registered level interrupt.
module tmr_cmp
  import tmr_cmp_pkg::*;
#(
  parameter int W      = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      TMR,
  input  logic [W-1:0]      PR,
  input  logic              EN_TMR,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wr_data,
  output logic [W-1:0]      rd_data,
  output logic              pwm_out,
  output logic              irq
);

  logic [W-1:0] ccr_shadow;
  logic [W-1:0] ccr_active;
  ctrl_t        ctrl;
  logic         match_f;
  logic         ovf_f;
  logic         ovf_ev;
  logic         match_ev;
  logic         pwm_raw;

  assign ovf_ev   = EN_TMR && (TMR >= PR);
  assign match_ev = EN_TMR && (TMR == ccr_active);
  assign pwm_raw  = ctrl.pwm_en && EN_TMR && (TMR < ccr_active);

  tmr_regs #(.W(W), .ADDR_W(ADDR_W)) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .match_ev   (match_ev),
    .ovf_ev     (ovf_ev),
    .ccr_shadow (ccr_shadow),
    .ctrl       (ctrl),
    .match_f    (match_f),
    .ovf_f      (ovf_f),
    .rd_data    (rd_data)
  );

  // Duty changes land only at the wrap, or at once while the timer is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_active <= '0;
      pwm_out    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ovf_ev || !EN_TMR) ccr_active <= ccr_shadow;
      pwm_out <= pwm_raw ^ ctrl.pwm_pol;
      irq     <= (match_f & ctrl.ie_match) | (ovf_f & ctrl.ie_ovf);
    end
  end

endmodule

// File: tb/tb_tmr_cmp.sv
// Directed bench for tmr_cmp; the bench itself plays the timer counter.
module tb_tmr_cmp;

  logic        clk;
  logic        rst_n;
  logic [15:0] tmr;
  logic [15:0] pr;
  logic        en_tmr;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        pwm_out;
  logic        irq;

  int total;
  int bad;

  tmr_cmp #(.W(16), .ADDR_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .TMR     (tmr),
    .PR      (pr),
    .EN_TMR  (en_tmr),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic run_cycle();
    @(posedge clk);
    @(negedge clk);
    if (en_tmr) tmr = (tmr >= pr) ? 16'd0 : tmr + 16'd1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    run_cycle();
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
    addr = a; rd_en = 1'b1;
    run_cycle();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  // Stop the timer, program CTRL/CCR, clear flags, restart from TMR=0.
  task automatic stop_load(input logic [15:0] ccr, input logic [15:0] ctrl);
    en_tmr = 1'b0;
    write_reg(2'd1, ctrl);
    write_reg(2'd0, ccr);
    write_reg(2'd2, 16'h0003);
    total++;
    if (pwm_out !== ctrl[3]) begin
      bad++;
      $display("FAIL stopped_pwm_is_pol: got %b want %b", pwm_out, ctrl[3]);
    end
    tmr = 16'd0;
    en_tmr = 1'b1;
  endtask

  // One full period from TMR=0; optional CCR write when TMR equals wr_at.
  task automatic run_period(input int duty, input logic pol, input int wr_at,
                            input logic [15:0] wr_val);
    int   n;
    logic exp;
    n = int'(pr) + 1;
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        addr = 2'd0; wr_data = wr_val; wr_en = 1'b1;
      end
      exp = (i < duty) ^ pol;
      run_cycle();
      wr_en = 1'b0;
      total++;
      if (pwm_out !== exp) begin
        bad++;
        $display("FAIL pwm duty=%0d pol=%b tmr=%0d: got %b want %b", duty, pol, i, pwm_out, exp);
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({pwm_out, irq, rd_data} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs: got pwm=%b irq=%b rd=%h want all 0", pwm_out, irq, rd_data);
    end
    run_cycle();
    total++;
    if (pwm_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_pwm_idle: got %b want 0", pwm_out);
    end
  endtask

  task automatic test_regs();
    logic [15:0] d;
    en_tmr = 1'b0;
    write_reg(2'd0, 16'h1234);
    write_reg(2'd1, 16'hFFFF);
    read_reg(2'd0, d);
    total++;
    if (d !== 16'h1234) begin bad++; $display("FAIL read_ccr: got %h want 1234", d); end
    total++;
    if (pwm_out !== 1'b1) begin bad++; $display("FAIL stopped_pol_high: got %b want 1", pwm_out); end
    read_reg(2'd1, d);
    total++;
    if (d !== 16'h000F) begin bad++; $display("FAIL read_ctrl_mask: got %h want 000f", d); end
    read_reg(2'd3, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL read_reserved: got %h want 0000", d); end
    read_reg(2'd2, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL read_status_idle: got %h want 0000", d); end
    addr = 2'd0; wr_data = 16'h0055; wr_en = 1'b1; rd_en = 1'b1;
    run_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if (rd_data !== 16'h1234) begin bad++; $display("FAIL rd_wr_same_cycle: got %h want 1234", rd_data); end
    run_cycle();
    total++;
    if (rd_data !== 16'h1234) begin bad++; $display("FAIL rd_data_hold: got %h want 1234", rd_data); end
    read_reg(2'd0, d);
    total++;
    if (d !== 16'h0055) begin bad++; $display("FAIL read_ccr_new: got %h want 0055", d); end
    write_reg(2'd1, 16'h0000);
  endtask

  task automatic test_pwm_basic();
    logic [15:0] d;
    pr = 16'd9;
    stop_load(16'd3, 16'h0001);
    run_period(3, 1'b0, -1, 16'd0);
    run_period(3, 1'b0, -1, 16'd0);
    read_reg(2'd2, d);
    total++;
    if (d !== 16'h0003) begin bad++; $display("FAIL status_after_run: got %h want 0003", d); end
  endtask

  task automatic test_ccr_update();
    stop_load(16'd3, 16'h0001);
    run_period(3, 1'b0, 5, 16'd7);
    run_period(7, 1'b0, 2, 16'd3);
    run_period(3, 1'b0, 9, 16'd7);
    run_period(3, 1'b0, -1, 16'd0);
    run_period(7, 1'b0, -1, 16'd0);
  endtask

  task automatic test_boundaries();
    stop_load(16'd0, 16'h0001);
    run_period(0, 1'b0, -1, 16'd0);
    stop_load(16'd12, 16'h0001);
    run_period(12, 1'b0, -1, 16'd0);
    stop_load(16'd0, 16'h0009);
    run_period(0, 1'b1, -1, 16'd0);
    stop_load(16'd12, 16'h0009);
    run_period(12, 1'b1, -1, 16'd0);
  endtask

  task automatic test_flags_irq();
    logic [15:0] d;
    pr = 16'd4;
    stop_load(16'd7, 16'h0004);
    repeat (4) run_cycle();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_before_ovf: got %b want 0", irq); end
    run_cycle();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_at_flag_edge: got %b want 0", irq); end
    read_reg(2'd2, d);
    total++;
    if (d !== 16'h0002) begin bad++; $display("FAIL ovf_flag_set: got %h want 0002", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_ovf_rise: got %b want 1", irq); end
    write_reg(2'd2, 16'h0002);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold_at_clear: got %b want 1", irq); end
    run_cycle();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b want 0", irq); end
    run_cycle();
    write_reg(2'd2, 16'h0002);
    read_reg(2'd2, d);
    total++;
    if (d !== 16'h0002) begin bad++; $display("FAIL set_beats_clear: got %h want 0002", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_after_set_wins: got %b want 1", irq); end
    stop_load(16'd2, 16'h000B);
    repeat (2) run_cycle();
    run_cycle();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_match_edge: got %b want 0", irq); end
    read_reg(2'd1, d);
    total++;
    if (d !== 16'h000B) begin bad++; $display("FAIL read_ctrl_b: got %h want 000b", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_match_rise: got %b want 1", irq); end
    total++;
    if (pwm_out !== 1'b1) begin bad++; $display("FAIL pwm_inv_tail: got %b want 1", pwm_out); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pwm_out, irq, rd_data} !== 18'h0) begin
      bad++;
      $display("FAIL async_reset: got pwm=%b irq=%b rd=%h want all 0", pwm_out, irq, rd_data);
    end
    en_tmr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(2'd0, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL post_reset_ccr: got %h want 0000", d); end
    read_reg(2'd1, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL post_reset_ctrl: got %h want 0000", d); end
    read_reg(2'd2, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL post_reset_status: got %h want 0000", d); end
    total++;
    if ({pwm_out, irq} !== 2'b00) begin bad++; $display("FAIL post_reset_outs: got %b want 00", {pwm_out, irq}); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; tmr = '0; pr = 16'd9; en_tmr = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_regs();
    test_pwm_basic();
    test_ccr_update();
    test_boundaries();
    test_flags_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
